// File: rtl/glitch_alarm_monitor_pkg.sv
// Shared types and helpers for the glitch alarm monitor: FSM state encoding,
// default widths and a saturating increment.
package glitch_mon_pkg;

    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_LEN_W   = 12;
    localparam int unsigned DEF_MIN_LEN = 1;
    localparam int unsigned DEF_HOLDOFF = 4;
    localparam int unsigned DEF_TS_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_HOLDOFF = 2'd3
    } mon_state_e;

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/glitch_alarm_monitor_if.sv
// Control/status bundle between host logic and glitch_alarm_monitor.
// Optional first_ts field exists only when GLITCH_TIMESTAMP_EN is defined.
interface glitch_alarm_monitor_if
    import glitch_mon_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned LEN_W = DEF_LEN_W
`ifdef GLITCH_TIMESTAMP_EN
    ,
    parameter int unsigned TS_W  = DEF_TS_W
`endif
) ();

    logic             arm;
    logic             alarm;
    logic             clr_req;
    logic             clr_ack;
    logic             irq;
    logic             glitch_active;
    logic [CNT_W-1:0] event_cnt;
    logic [LEN_W-1:0] max_len;
`ifdef GLITCH_TIMESTAMP_EN
    logic [TS_W-1:0]  first_ts;

    modport master (output arm, alarm, clr_req,
                    input  clr_ack, irq, glitch_active, event_cnt, max_len, first_ts);
    modport slave  (input  arm, alarm, clr_req,
                    output clr_ack, irq, glitch_active, event_cnt, max_len, first_ts);
`else
    modport master (output arm, alarm, clr_req,
                    input  clr_ack, irq, glitch_active, event_cnt, max_len);
    modport slave  (input  arm, alarm, clr_req,
                    output clr_ack, irq, glitch_active, event_cnt, max_len);
`endif

endinterface

// File: rtl/glitch_alarm_monitor_sat_counter.sv
// Saturating up-counter. clr has priority; clr together with inc loads 1
// so a clear and a new count on the same edge leave a count of one.
module sat_counter
    import glitch_mon_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o
);

    localparam logic [31:0] MAX_V = 32'((64'd1 << W) - 64'd1);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = inc_i ? W'(1) : '0;
        end else if (inc_i) begin
            q_d = W'(sat_inc(32'(q_q), MAX_V));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/glitch_alarm_monitor.sv
// Qualifies glitch-detector alarm pulses, counts events, tracks the longest
// pulse and raises a sticky irq. Optional timestamp: GLITCH_TIMESTAMP_EN.
module glitch_alarm_monitor
    import glitch_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned MIN_LEN = DEF_MIN_LEN,
    parameter int unsigned HOLDOFF = DEF_HOLDOFF
`ifdef GLITCH_TIMESTAMP_EN
    ,
    parameter int unsigned TS_W    = DEF_TS_W
`endif
) (
    input logic                   clk_ps,
    input logic                   rst_ps,
    glitch_alarm_monitor_if.slave mon
);

    localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    mon_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              irq_q, irq_d;
    logic              clr_ack_q;
    logic              clr_blk_q, clr_blk_d;
    logic              active_q;
    logic              len_inc, len_clr, evt, pulse_end, clr_fire;

    // Pulse qualification FSM.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        len_inc   = 1'b0;
        len_clr   = 1'b0;
        evt       = 1'b0;
        pulse_end = 1'b0;
        if (!mon.arm) begin
            state_d = ST_IDLE;
            len_clr = 1'b1;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mon.alarm) begin
                        len_clr = 1'b1;
                        len_inc = 1'b1;
                        if (MIN_LEN == 1) begin
                            state_d = ST_ACTIVE;
                            evt     = 1'b1;
                        end else begin
                            state_d = ST_QUAL;
                        end
                    end
                end
                ST_QUAL: begin
                    if (mon.alarm) begin
                        len_inc = 1'b1;
                        if (32'(len_q) + 32'd1 == MIN_LEN) begin
                            state_d = ST_ACTIVE;
                            evt     = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        len_clr = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (mon.alarm) begin
                        len_inc = 1'b1;
                    end else begin
                        pulse_end = 1'b1;
                        len_clr   = 1'b1;
                        hold_d    = '0;
                        state_d   = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (32'(hold_q) + 32'd1 >= HOLDOFF) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_q + HOLD_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Clear handshake and status; a same-edge clear is applied before the event/pulse end.
    always_comb begin
        clr_fire  = mon.clr_req && !clr_ack_q && !clr_blk_q;
        clr_blk_d = clr_blk_q;
        if (clr_fire)          clr_blk_d = 1'b1;
        else if (!mon.clr_req) clr_blk_d = 1'b0;

        irq_d = irq_q;
        if (clr_fire) irq_d = 1'b0;
        if (evt)      irq_d = 1'b1;

        max_d = max_q;
        if (clr_fire) max_d = '0;
        if (pulse_end && (len_q > max_d)) max_d = len_q;
    end

    always_ff @(posedge clk_ps or posedge rst_ps) begin
        if (rst_ps) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            max_q     <= '0;
            irq_q     <= 1'b0;
            clr_ack_q <= 1'b0;
            clr_blk_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            max_q     <= max_d;
            irq_q     <= irq_d;
            clr_ack_q <= clr_fire;
            clr_blk_q <= clr_blk_d;
            active_q  <= (state_d == ST_ACTIVE);
        end
    end

    sat_counter #(.W(LEN_W)) u_len (
        .clk   (clk_ps),
        .rst   (rst_ps),
        .inc_i (len_inc),
        .clr_i (len_clr),
        .q_o   (len_q)
    );

    sat_counter #(.W(CNT_W)) u_evt (
        .clk   (clk_ps),
        .rst   (rst_ps),
        .inc_i (evt),
        .clr_i (clr_fire),
        .q_o   (cnt_q)
    );

    assign mon.event_cnt     = cnt_q;
    assign mon.max_len       = max_q;
    assign mon.irq           = irq_q;
    assign mon.clr_ack       = clr_ack_q;
    assign mon.glitch_active = active_q;

`ifdef GLITCH_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, first_ts_q, first_ts_d;
    logic            ts_have_q, ts_have_d;

    // Capture the free-running timestamp on the first event since reset/clear.
    always_comb begin
        first_ts_d = first_ts_q;
        ts_have_d  = ts_have_q;
        if (clr_fire) begin
            first_ts_d = '0;
            ts_have_d  = 1'b0;
        end
        if (evt && !ts_have_d) begin
            first_ts_d = ts_q;
            ts_have_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_ps or posedge rst_ps) begin
        if (rst_ps) begin
            ts_q       <= '0;
            first_ts_q <= '0;
            ts_have_q  <= 1'b0;
        end else begin
            ts_q       <= ts_q + TS_W'(1);
            first_ts_q <= first_ts_d;
            ts_have_q  <= ts_have_d;
        end
    end

    assign mon.first_ts = first_ts_q;
`endif

endmodule

// File: tb/tb_glitch_alarm_monitor.sv
// Bench for glitch_alarm_monitor: three configurations share one stimulus
// stream and are compared each cycle against a pulse-level reference model.
module tb_glitch_alarm_monitor;

    logic clk_ps = 1'b0;
    logic rst_ps = 1'b1;
    logic arm = 1'b0, alarm = 1'b0, clr_req = 1'b0;

    always #5 clk_ps = ~clk_ps;

    glitch_alarm_monitor_if #(.CNT_W(4),  .LEN_W(5))  if0 ();
    glitch_alarm_monitor_if #(.CNT_W(16), .LEN_W(12)) if1 ();
    glitch_alarm_monitor_if                            if2 ();

    assign if0.arm = arm;  assign if0.alarm = alarm;  assign if0.clr_req = clr_req;
    assign if1.arm = arm;  assign if1.alarm = alarm;  assign if1.clr_req = clr_req;
    assign if2.arm = arm;  assign if2.alarm = alarm;  assign if2.clr_req = clr_req;

    glitch_alarm_monitor #(.CNT_W(4), .LEN_W(5), .MIN_LEN(1), .HOLDOFF(0)) u_dut0 (
        .clk_ps(clk_ps), .rst_ps(rst_ps), .mon(if0));
    glitch_alarm_monitor #(.CNT_W(16), .LEN_W(12), .MIN_LEN(3), .HOLDOFF(4)) u_dut1 (
        .clk_ps(clk_ps), .rst_ps(rst_ps), .mon(if1));
    glitch_alarm_monitor u_dut2 (
        .clk_ps(clk_ps), .rst_ps(rst_ps), .mon(if2));

    // Reference configuration per DUT.
    localparam int MIN_L[3]  = '{1, 3, 1};
    localparam int HOLD[3]   = '{0, 4, 4};
    localparam int LEN_MX[3] = '{31, 4095, 4095};
    localparam int CNT_MX[3] = '{15, 65535, 65535};

    // Model state: length of the current high run, remaining ignored samples,
    // event count and longest qualified pulse.
    int run[3], ho[3], cnt[3], mx[3];
    bit ack_exp, clr_seen_low;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            run[i] = 0; ho[i] = 0; cnt[i] = 0; mx[i] = 0;
        end
        ack_exp      = 1'b0;
        clr_seen_low = 1'b1;
    endtask

    task automatic model_step();
        bit fire;
        int l;
        fire = clr_req && !ack_exp && clr_seen_low;
        if (fire)         clr_seen_low = 1'b0;
        else if (!clr_req) clr_seen_low = 1'b1;
        ack_exp = fire;
        for (int i = 0; i < 3; i++) begin
            if (fire) begin cnt[i] = 0; mx[i] = 0; end
            if (!arm) begin
                run[i] = 0; ho[i] = 0;
            end else if (ho[i] > 0) begin
                ho[i]--;
            end else if (alarm) begin
                run[i]++;
                if (run[i] == MIN_L[i] && cnt[i] < CNT_MX[i]) cnt[i]++;
            end else begin
                if (run[i] >= MIN_L[i]) begin
                    l = (run[i] > LEN_MX[i]) ? LEN_MX[i] : run[i];
                    if (l > mx[i]) mx[i] = l;
                    ho[i] = HOLD[i];
                end
                run[i] = 0;
            end
        end
    endtask

    task automatic check_dut(input int i, input logic [63:0] c, input logic [63:0] m,
                             input logic q, input logic a, input logic act);
        check_eq($sformatf("cnt%0d", i), c, 64'(cnt[i]));
        check_eq($sformatf("maxlen%0d", i), m, 64'(mx[i]));
        check_eq($sformatf("irq%0d", i), 64'(q), 64'(cnt[i] != 0));
        check_eq($sformatf("ack%0d", i), 64'(a), 64'(ack_exp));
        check_eq($sformatf("active%0d", i), 64'(act), 64'(run[i] >= MIN_L[i]));
    endtask

    task automatic compare_all();
        check_dut(0, 64'(if0.event_cnt), 64'(if0.max_len), if0.irq, if0.clr_ack, if0.glitch_active);
        check_dut(1, 64'(if1.event_cnt), 64'(if1.max_len), if1.irq, if1.clr_ack, if1.glitch_active);
        check_dut(2, 64'(if2.event_cnt), 64'(if2.max_len), if2.irq, if2.clr_ack, if2.glitch_active);
    endtask

    task automatic cycle(input bit a, input bit al, input bit c);
        @(negedge clk_ps);
        arm = a; alarm = al; clr_req = c;
        @(posedge clk_ps);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        cycle(1'b1, 1'b0, 1'b1);
        idle(6);
    endtask

    int acks;
    bit ral, rarm, rclr;

    initial begin
        model_reset();
        repeat (3) @(posedge clk_ps);
        #1;
        compare_all();
        @(negedge clk_ps);
        rst_ps = 1'b0;
        idle(2);

        // Three single-cycle pulses, three cycles apart.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 1'b0);
            idle(2);
        end
        check_eq("tp1_cnt", 64'(if0.event_cnt), 64'd3);
        check_eq("tp1_max", 64'(if0.max_len), 64'd1);
        check_eq("tp1_irq", 64'(if0.irq), 64'd1);
        do_clear();

        // Short pulse below MIN_LEN=3, then a 5-cycle pulse.
        cycle(1'b1, 1'b1, 1'b0); cycle(1'b1, 1'b1, 1'b0); idle(1);
        check_eq("tp2_short_cnt", 64'(if1.event_cnt), 64'd0);
        check_eq("tp2_short_irq", 64'(if1.irq), 64'd0);
        cycle(1'b1, 1'b1, 1'b0); cycle(1'b1, 1'b1, 1'b0);
        check_eq("tp2_pre_cnt", 64'(if1.event_cnt), 64'd0);
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("tp2_third_cnt", 64'(if1.event_cnt), 64'd1);
        cycle(1'b1, 1'b1, 1'b0); cycle(1'b1, 1'b1, 1'b0); idle(1);
        check_eq("tp2_max", 64'(if1.max_len), 64'd5);
        idle(5);
        do_clear();

        // Holdoff masking: 2 high, 1 low, 2 high, 5 low, 1 high.
        cycle(1'b1, 1'b1, 1'b0); cycle(1'b1, 1'b1, 1'b0); idle(1);
        cycle(1'b1, 1'b1, 1'b0); cycle(1'b1, 1'b1, 1'b0); idle(5);
        cycle(1'b1, 1'b1, 1'b0); idle(6);
        check_eq("tp3_cnt", 64'(if2.event_cnt), 64'd2);
        do_clear();

        // Event counter saturation on the 4-bit instance.
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b1, 1'b0);
            cycle(1'b1, 1'b0, 1'b0);
        end
        check_eq("tp4_sat", 64'(if0.event_cnt), 64'd15);
        check_eq("tp4_irq", 64'(if0.irq), 64'd1);
        idle(5);

        // Clear on the same edge as a qualifying sample, then a held clear.
        cycle(1'b1, 1'b1, 1'b1);
        check_eq("tp5_ack", 64'(if0.clr_ack), 64'd1);
        check_eq("tp5_cnt", 64'(if0.event_cnt), 64'd1);
        check_eq("tp5_irq", 64'(if0.irq), 64'd1);
        idle(6);
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 1'b1);
            acks += int'(if0.clr_ack);
        end
        idle(1);
        check_eq("tp5_single_ack", 64'(acks), 64'd1);

        // Length saturation on the 5-bit instance.
        for (int k = 0; k < 40; k++) cycle(1'b1, 1'b1, 1'b0);
        idle(6);
        check_eq("lensat_max", 64'(if0.max_len), 64'd31);
        do_clear();

        // arm dropped mid-ACTIVE discards the pulse.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0);
        idle(6);
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check_eq("tp6_max", 64'(if1.max_len), 64'd3);
        check_eq("tp6_active", 64'(if1.glitch_active), 64'd0);
        check_eq("tp6_cnt", 64'(if1.event_cnt), 64'd2);
        idle(3);

        // Asynchronous reset in the middle of a pulse.
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b0);
        @(posedge clk_ps);
        model_step();
        #3;
        rst_ps = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk_ps);
        rst_ps = 1'b0; arm = 1'b0; alarm = 1'b0; clr_req = 1'b0;
        @(posedge clk_ps);
        model_step();
        #1;
        compare_all();

        // Randomized traffic.
        ral = 1'b0; rarm = 1'b1; rclr = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 5) == 0)  ral  = ~ral;
            if ($urandom_range(0, 59) == 0) rarm = ~rarm;
            if ($urandom_range(0, 39) == 0) rclr = ~rclr;
            if ($urandom_range(0, 299) == 0) begin
                for (int j = 0; j < 45; j++) cycle(1'b1, 1'b1, 1'b0);
            end
            cycle(rarm, ral, rclr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
